// File: rtl/spi_slave_if_if.sv
// Board-level SPI pins plus the host-side tx/rx byte handshake of the spi_slave_if target.
// The target connects through the slave modport; the driving agent uses the master modport.
interface spi_slave_if_if #(
    parameter int WIDTH = 8
);
    logic             sclk;
    logic             cs;
    logic             mosi;
    logic             miso;
    logic             miso_oe;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             frame_err;

    modport slave (
        input  sclk, cs, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, frame_err
    );

    modport master (
        output sclk, cs, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, frame_err
    );
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 target: MSB-first MOSI bytes become rx_data strobes, tx bytes (or IDLE_BYTE) go out on MISO.
// Define SPI_SLAVE_SYNC_EN to pass sclk/cs/mosi through 2-flop synchronisers (+2 clk latency).
module spi_slave_if #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_BYTE = WIDTH'(8'hFF)
) (
    input logic           clk,
    input logic           rst,
    spi_slave_if_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             sclk_s;
    logic             cs_s;
    logic             mosi_s;
    logic             sclk_q;
    logic             cs_q;
    logic             rise;
    logic             fall;
    logic             cs_fall;
    logic             cs_rise;
    logic             selected;
    logic             sample;
    logic             complete;
    logic             load_now;
    logic             frame_err_d;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_after;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_data_r;
    logic             rx_valid_r;
    logic             frame_err_r;

`ifdef SPI_SLAVE_SYNC_EN
    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[0], bus.sclk};
            cs_sync   <= {cs_sync[0], bus.cs};
            mosi_sync <= {mosi_sync[0], bus.mosi};
        end
    end

    assign sclk_s = sclk_sync[1];
    assign cs_s   = cs_sync[1];
    assign mosi_s = mosi_sync[1];
`else
    assign sclk_s = bus.sclk;
    assign cs_s   = bus.cs;
    assign mosi_s = bus.mosi;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= 1'b0;
            cs_q   <= 1'b1;
        end else begin
            sclk_q <= sclk_s;
            cs_q   <= cs_s;
        end
    end

    assign rise    = sclk_s & ~sclk_q;
    assign fall    = ~sclk_s & sclk_q;
    assign cs_fall = ~cs_s & cs_q;
    assign cs_rise = cs_s & ~cs_q;

    // Gating on cs_q lets the final rise that coincides with cs_rise still be sampled.
    assign selected = ~cs_q && (state != IDLE);
    assign sample   = selected & rise;
    assign complete = (bit_cnt == FULL_CNT);

    assign cnt_base  = (state == LOAD || complete) ? '0 : bit_cnt;
    assign cnt_after = sample ? cnt_base + CNT_W'(1) : cnt_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        load_now    = 1'b0;
        frame_err_d = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                next_state = SHIFT;
                load_now   = 1'b1;
            end
            SHIFT: begin
                if (complete) begin
                    load_now = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (cs_rise) begin
            next_state  = IDLE;
            load_now    = 1'b0;
            frame_err_d = (cnt_after != '0) && (cnt_after != FULL_CNT);
        end
    end

    // A fall with bit_cnt==0 is the trailing edge of the previous byte and must not
    // shift away the MSB just reloaded for the next byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= IDLE_BYTE;
            rx_data_r   <= '0;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rx_valid_r  <= complete;
            frame_err_r <= frame_err_d;
            if (complete) begin
                rx_data_r <= rx_shift;
            end
            if (load_now) begin
                tx_shift <= bus.tx_valid ? bus.tx_data : IDLE_BYTE;
            end else if (selected && fall && (bit_cnt != '0) && !complete) begin
                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            end
            if (frame_err_d) begin
                rx_shift <= '0;
                bit_cnt  <= '0;
            end else if (sample) begin
                rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
                bit_cnt  <= cnt_after;
            end else begin
                bit_cnt <= cnt_base;
            end
        end
    end

    assign bus.miso      = ~cs_q & tx_shift[WIDTH-1];
    assign bus.miso_oe   = ~cs_q;
    assign bus.tx_ready  = load_now & bus.tx_valid;
    assign bus.rx_data   = rx_data_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.frame_err = frame_err_r;
endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: acts as SPI master and compares whole frames
// against a byte-level model of what the target should receive, return and flag.
module tb_spi_slave_if;
`ifdef SPI_SLAVE_SYNC_EN
    localparam int LEAD     = 6;
    localparam int HALF_ADD = 3;
    localparam int RX_LAT   = 4;
`else
    localparam int LEAD     = 3;
    localparam int HALF_ADD = 0;
    localparam int RX_LAT   = 2;
`endif

    logic clk = 1'b0;
    logic rst;

    spi_slave_if_if #(.WIDTH(8)) bus ();

    spi_slave_if #(
        .WIDTH    (8),
        .IDLE_BYTE(8'hFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    int          rx_cyc       = 0;
    int          err_pulses   = 0;
    int          ready_pulses = 0;
    int          last_rise_cyc = 0;
    int          tx_idx       = 0;
    int          tx_cnt       = 0;
    logic [15:0] tx_word      = '0;
    logic [7:0]  last_rx      = '0;
    logic [7:0]  rx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Strobes are collected mid-cycle, well away from the sampling edge.
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_q.push_back(bus.rx_data);
            rx_cyc = cyc;
        end
        if (bus.frame_err) err_pulses++;
        if (bus.tx_ready) ready_pulses++;
    end

    task check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task present_tx();
        if (tx_idx < tx_cnt) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = tx_word[15 - 8*tx_idx -: 8];
        end else begin
            bus.tx_valid = 1'b0;
            bus.tx_data  = 8'h00;
        end
    endtask

    task tick();
        logic hs;
        @(negedge clk);
        hs = bus.tx_ready;
        @(posedge clk);
        #2;
        if (hs && tx_idx < tx_cnt) begin
            tx_idx++;
            present_tx();
        end
    endtask

    task automatic apply_stimulus(input int nbits, input logic [15:0] mosi_word, input int ntx,
                                  input logic [15:0] txw, input int half_in, input bit coincide);
        int          half      = half_in + HALF_ADD;
        int          full      = nbits / 8;
        int          slots;
        int          exp_ready;
        int          k;
        logic [15:0] miso_got  = '0;
        logic [15:0] miso_exp  = '0;
        logic [7:0]  slot_byte;
        logic [7:0]  exp_q[$];

        rx_q.delete();
        err_pulses   = 0;
        ready_pulses = 0;
        tx_word      = txw;
        tx_cnt       = ntx;
        tx_idx       = 0;
        present_tx();
        bus.mosi = mosi_word[15];
        bus.cs   = 1'b0;
        repeat (LEAD) tick();
        for (int i = 0; i < nbits; i++) begin
            if (i == 0) check_output("miso_oe_sel", 32'(bus.miso_oe), 32'd1);
            miso_got = {miso_got[14:0], bus.miso};
            bus.sclk = 1'b1;
            last_rise_cyc = cyc;
            if (coincide && i == nbits - 1) bus.cs = 1'b1;
            repeat (half) tick();
            bus.sclk = 1'b0;
            if (i + 1 < nbits) bus.mosi = mosi_word[14 - i];
            repeat (half) tick();
        end
        if (!coincide) begin
            repeat (2) tick();
            bus.cs = 1'b1;
        end
        repeat (10) tick();
        tx_cnt = 0;
        present_tx();

        // Byte-level model: complete bytes are received, each byte slot returns the
        // queued tx byte or 0xFF, a slot opens at frame start and after every byte
        // finished while still selected.
        for (int b = 0; b < full; b++) exp_q.push_back(mosi_word[15 - 8*b -: 8]);
        for (int i = 0; i < nbits; i++) begin
            k = i / 8;
            slot_byte = (k < ntx) ? txw[15 - 8*k -: 8] : 8'hFF;
            miso_exp  = {miso_exp[14:0], slot_byte[7 - (i % 8)]};
        end
        slots     = ((nbits % 8) != 0 || !coincide) ? full + 1 : full;
        exp_ready = (ntx < slots) ? ntx : slots;
        if (full > 0) last_rx = exp_q[full-1];

        check_output("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int b = 0; b < exp_q.size(); b++) begin
            if (b < rx_q.size()) check_output("rx_byte", 32'(rx_q[b]), 32'(exp_q[b]));
        end
        check_output("rx_data_hold", 32'(bus.rx_data), 32'(last_rx));
        check_output("frame_err", 32'(err_pulses), ((nbits % 8) != 0) ? 32'd1 : 32'd0);
        check_output("tx_ready", 32'(ready_pulses), 32'(exp_ready));
        check_output("miso_bits", 32'(miso_got), 32'(miso_exp));
        check_output("miso_oe_idle", 32'(bus.miso_oe), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.cs       = 1'b0;
        bus.sclk     = 1'b0;
        bus.mosi     = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            bus.sclk = ~bus.sclk;
            bus.mosi = ~bus.mosi;
            tick();
        end
        @(negedge clk);
        check_output("rst_miso", 32'(bus.miso), 32'd0);
        check_output("rst_miso_oe", 32'(bus.miso_oe), 32'd0);
        check_output("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        check_output("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check_output("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check_output("rst_frame_err", 32'(bus.frame_err), 32'd0);
        @(posedge clk);
        #2;
        bus.cs       = 1'b1;
        bus.sclk     = 1'b0;
        bus.mosi     = 1'b0;
        bus.tx_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        rx_q.delete();
        err_pulses   = 0;
        ready_pulses = 0;
        repeat (8) tick();
        check_output("post_rst_miso_oe", 32'(bus.miso_oe), 32'd0);
        check_output("post_rst_rx", 32'(rx_q.size()), 32'd0);
        check_output("post_rst_err", 32'(err_pulses + ready_pulses), 32'd0);

        apply_stimulus(8, 16'hA500, 0, 16'h0000, 1, 1'b0);
        check_output("rx_latency", 32'(rx_cyc - last_rise_cyc), 32'(RX_LAT));
        apply_stimulus(8, 16'h5A00, 1, 16'h3C00, 2, 1'b0);
        apply_stimulus(16, 16'h1234, 0, 16'h0000, 1, 1'b0);
        apply_stimulus(5, 16'hD800, 0, 16'h0000, 2, 1'b0);
        apply_stimulus(8, 16'h8100, 0, 16'h0000, 1, 1'b0);
        apply_stimulus(8, 16'hF000, 0, 16'h0000, 2, 1'b1);
        apply_stimulus(16, 16'hC3E7, 2, 16'h6699, 3, 1'b0);

        for (int n = 0; n < 24; n++) begin
            int nb;
            bit co;
            nb = $urandom_range(16, 1);
            co = ((nb % 8) == 0) && ($urandom_range(1, 0) == 1);
            apply_stimulus(nb, 16'($urandom), $urandom_range(2, 0), 16'($urandom),
                           $urandom_range(3, 1), co);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Target-side SPI endpoint that consumes the master's serial stream (sclk, cs, MOSI) and drives MISO back to the master's serial input.
- Deserialises MSB-first frames into parallel rx bytes with a one-cycle valid strobe.
- Serialises a host-supplied tx byte, or a fixed idle byte, on MISO.
- Sits directly downstream of the SPI master on the same board-level bus; used as the loopback/peer model and as synthesizable target logic.

Parameters:
- WIDTH, 8, frame width in bits; both shift registers and the bit counter are sized from it.
- IDLE_BYTE, 8'hFF, value shifted out on MISO when no tx byte is queued at frame/byte start.

Ports:
- clk  input  1  system clock; same domain as the master's sclk/cs generation.
- rst  input  1  synchronous reset, active-high.
- sclk  input  1  serial clock from master.
- cs  input  1  chip select from master, active-low.
- mosi  input  1  serial data from master (master's so).
- miso  output  1  serial data to master (master's si).
- miso_oe  output  1  MISO drive enable; high only while selected.
- tx_data  input  WIDTH  byte to return on next byte slot.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  one-cycle pulse; tx_data was consumed this cycle.
- rx_data  output  WIDTH  last completed received byte; held until the next byte completes.
- rx_valid  output  1  one-cycle pulse; rx_data updated.
- frame_err  output  1  one-cycle pulse; cs deasserted with a partial byte.

Behaviour:
- Reset (rst=1 at posedge clk): state=IDLE, bit_cnt=0, rx_shift=0, tx_shift=IDLE_BYTE, sclk_q=0, cs_q=1; outputs miso=0, miso_oe=0, tx_ready=0, rx_data=0, rx_valid=0, frame_err=0. Reset overrides any frame in progress; no strobes are generated for the aborted frame.
- Edge detect: sclk_q/cs_q are registered copies. rise = sclk & ~sclk_q; fall = ~sclk & sclk_q; cs_fall = ~cs & cs_q; cs_rise = cs & ~cs_q.
- States:
  - IDLE, cs high. On cs_fall go to LOAD.
  - LOAD, single cycle: tx_shift <= tx_valid ? tx_data : IDLE_BYTE; tx_ready pulses iff tx_valid; bit_cnt=0; go to SHIFT. Any rise occurring in the LOAD cycle is still sampled.
  - SHIFT:
    - On rise: rx_shift <= {rx_shift[WIDTH-2:0], mosi}; bit_cnt++.
    - On fall: tx_shift <= {tx_shift[WIDTH-2:0], 1'b0}.
  - Byte complete: when bit_cnt reaches WIDTH on a rise, the next clk asserts rx_valid=1 for one cycle with rx_data = the full assembled byte, bit_cnt wraps to 0, and tx_shift reloads as in LOAD (multi-byte frames). The reload has priority over a coincident fall shift.
- miso = tx_shift[WIDTH-1] while cs low, else 0. miso_oe = ~cs_q.
- cs_rise in any state returns to IDLE.
  - If bit_cnt != 0 at cs_rise: frame_err pulses and the partial rx_shift is discarded; rx_data is unchanged.
  - If bit_cnt == 0 at cs_rise: no error.
- Simultaneous cs_rise and the final rise: the byte completes (rx_valid pulses), there is no frame_err, and the state goes to IDLE.
- mosi is sampled only while selected; rise/fall events while cs high are ignored.
- With the sync option off, the inputs are treated as synchronous to clk. This is valid because the master toggles sclk on clk edges.

Optional Feature:
- Macro SPI_SLAVE_SYNC_EN.
- Defined: sclk, cs and mosi each pass through a 2-flop synchroniser (reset to 0/1/0) before edge detection.
  - Adds 2 clk of latency to all events.
  - Requires the sclk half-period to be at least 2 clk.
- Undefined: inputs are used directly, with no added latency.

Test Plan:
- Reset with cs=0 and sclk toggling -> all outputs at reset values; after rst release with cs=1, miso_oe=0 and no strobes.
- cs low, mosi drives 8'hA5 MSB-first over 8 sclk rises -> rx_valid single pulse with rx_data=8'hA5, one clk after the 8th rise.
- tx_valid=1, tx_data=8'h3C at cs_fall -> tx_ready pulses once; miso presents 0,0,1,1,1,1,0,0 on successive rises.
- Two-byte frame with tx_valid=0 throughout, mosi 8'h12 then 8'h34 -> rx_valid pulses twice (8'h12, then 8'h34); miso=1 for all 16 bits (IDLE_BYTE); frame_err=0.
- cs raised after 5 rises -> frame_err single pulse; rx_valid=0; rx_data keeps its previous value; the next frame receives 8'h81 correctly.
- cs rise coincident with the 8th rise, mosi 8'hF0 -> rx_valid with 8'hF0; no frame_err; state returns to IDLE.
